// File: rtl/rvvireorder_if.sv
// Bundles the three handshake channels of the RVVI receive-side reorder
// block: incoming packets (Rx), acknowledgements back to the transmitter
// (Ack) and in-order delivery to the trace consumer (Out).
interface rvvireorder_if #(
  parameter int Entries = 3,
  parameter int WIDTH   = 792
);

  // Incoming packet channel
  logic               RxValid;
  logic [WIDTH-1:0]   RxData;
  logic               RxReady;

  // Acknowledge channel toward the transmitter
  logic               AckValid;
  logic [Entries:0]   AckTag;
  logic               AckReady;

  // In-order delivery channel
  logic               OutValid;
  logic [WIDTH-1:0]   OutData;
  logic               OutReady;

  // Drop statistics
  logic [15:0]        DupCount;

  // Transmitter / consumer side: drives packets, consumes acks and output
  modport master (
    output RxValid, RxData, AckReady, OutReady,
    input  RxReady, AckValid, AckTag, OutValid, OutData, DupCount
  );

  // Reorder block side
  modport slave (
    input  RxValid, RxData, AckReady, OutReady,
    output RxReady, AckValid, AckTag, OutValid, OutData, DupCount
  );

endinterface

// File: rtl/rvvireorder.sv
// RVVI receive-side reorder window.
// Packets arrive tagged with an (Entries+1)-bit sequence number, possibly out
// of order, duplicated or replayed. Each accepted packet is acked; new ones
// are parked in a slot indexed by the low tag bits and released strictly in
// sequence order. The extra tag bit distinguishes "ahead of the head" from
// "already delivered" so replays of old packets are recognised as stale.
module rvvireorder #(
  parameter int Entries = 3,
  parameter int WIDTH   = 792,
  parameter int TAGLSB  = 160
) (
  input  logic           clk,
  input  logic           resetn,
  rvvireorder_if.slave   bus
);

  localparam int DEPTH = 1 << Entries;
  localparam int TW    = Entries + 1;

  // Window storage (payload is not reset; only the valid bits are)
  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;

  // Sequence number expected at the head of the window
  logic [TW-1:0]      exp_seq_q, exp_seq_d;

  // Ack register
  logic               ack_valid_q, ack_valid_d;
  logic [TW-1:0]      ack_tag_q, ack_tag_d;

  // Saturating drop counter
  logic [15:0]        dup_count_q, dup_count_d;

  // Decoded receive-side signals
  logic [TW-1:0]      rx_tag;
  logic [Entries-1:0] rx_slot;
  logic [TW-1:0]      rx_dist;
  logic               rx_in_window;
  logic               rx_ready;
  logic               rx_fire;
  logic               rx_new;
  logic               rx_drop;

  // Head-of-window signals
  logic [Entries-1:0] head_slot;
  logic               head_valid;
  logic               pop;

  assign rx_tag       = bus.RxData[TAGLSB +: TW];
  assign rx_slot      = rx_tag[Entries-1:0];
  // Modular distance ahead of the head; the MSB set means the tag lies in
  // the half of sequence space that has already been delivered.
  assign rx_dist      = rx_tag - exp_seq_q;
  assign rx_in_window = ~rx_dist[Entries];

  // The ack register can take a new tag whenever it is empty or being
  // drained this cycle, so a steady AckReady gives one accept per cycle.
  assign rx_ready     = ~ack_valid_q | bus.AckReady;
  assign rx_fire      = bus.RxValid & rx_ready;
  assign rx_new       = rx_fire & rx_in_window & ~valid_q[rx_slot];
  assign rx_drop      = rx_fire & ~rx_new;

  assign head_slot    = exp_seq_q[Entries-1:0];
  assign head_valid   = valid_q[head_slot];
  assign pop          = head_valid & bus.OutReady;

  assign bus.RxReady  = rx_ready;
  assign bus.AckValid = ack_valid_q;
  assign bus.AckTag   = ack_tag_q;
  assign bus.OutValid = head_valid;
  assign bus.OutData  = mem_q[head_slot];
  assign bus.DupCount = dup_count_q;

  // Valid bitmap update. A new write can never land on the slot being
  // popped: that slot is only reachable with distance 2^Entries, which is
  // classified stale, so both updates are applied independently.
  always_comb begin
    valid_d = valid_q;
    if (pop) begin
      valid_d[head_slot] = 1'b0;
    end
    if (rx_new) begin
      valid_d[rx_slot] = 1'b1;
    end
  end

  // Head pointer advances on every delivered packet and wraps naturally.
  always_comb begin
    exp_seq_d = exp_seq_q;
    if (pop) begin
      exp_seq_d = exp_seq_q + TW'(1);
    end
  end

  // Every accepted packet, dropped or not, is acked so the transmitter can
  // retire entries whose earlier ack was lost.
  always_comb begin
    ack_valid_d = ack_valid_q;
    ack_tag_d   = ack_tag_q;
    if (rx_fire) begin
      ack_valid_d = 1'b1;
      ack_tag_d   = rx_tag;
    end else if (bus.AckReady) begin
      ack_valid_d = 1'b0;
    end
  end

  // Duplicates and stale replays are counted, saturating at all-ones.
  always_comb begin
    dup_count_d = dup_count_q;
    if (rx_drop && (dup_count_q != 16'hFFFF)) begin
      dup_count_d = dup_count_q + 16'd1;
    end
  end

  // Control state; reset discards buffered packets and any pending ack.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q     <= '0;
      exp_seq_q   <= '0;
      ack_valid_q <= 1'b0;
      ack_tag_q   <= '0;
      dup_count_q <= '0;
    end else begin
      valid_q     <= valid_d;
      exp_seq_q   <= exp_seq_d;
      ack_valid_q <= ack_valid_d;
      ack_tag_q   <= ack_tag_d;
      dup_count_q <= dup_count_d;
    end
  end

  // Payload storage, written only for packets classified as new.
  always_ff @(posedge clk) begin
    if (rx_new) begin
      mem_q[rx_slot] <= bus.RxData;
    end
  end

endmodule

// File: tb/tb_rvvireorder.sv
module tb_rvvireorder;

  localparam int E  = 3;
  localparam int W  = 792;
  localparam int TL = 160;
  localparam int NT = 16;   // size of tag space
  localparam int ND = 8;    // window depth

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  rvvireorder_if #(.Entries(E), .WIDTH(W)) bus ();

  rvvireorder #(.Entries(E), .WIDTH(W), .TAGLSB(TL)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Reference model: packets waiting for delivery keyed by absolute tag
  logic [W-1:0] m_win [int];
  int           m_exp;
  bit           m_ack_v;
  int           m_ack_tag;
  int           m_dup;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] held_data;
  int           saved_dup;

  task automatic chk(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] make_pkt(input int tag);
    logic [W-1:0] p;
    p = '0;
    for (int i = 0; i < 25; i++) p = {p[W-33:0], 32'($urandom)};
    p[TL +: E+1] = (E+1)'(tag);
    return p;
  endfunction

  function automatic int modt(input int v);
    return ((v % NT) + NT) % NT;
  endfunction

  task automatic clear_model();
    m_win.delete();
    m_exp     = 0;
    m_ack_v   = 0;
    m_ack_tag = 0;
    m_dup     = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs against the model,
  // then advance the model by the handshakes it predicts.
  task automatic cycle(input bit rv, input int tag_in, input bit ar, input bit orr);
    logic [W-1:0] pkt;
    int  tag, d;
    bit  exp_ready, exp_ov;
    tag = modt(tag_in);
    @(negedge clk);
    pkt = make_pkt(tag);
    bus.RxValid  = rv;
    bus.RxData   = pkt;
    bus.AckReady = ar;
    bus.OutReady = orr;
    #1;
    exp_ready = !m_ack_v || ar;
    exp_ov    = m_win.exists(m_exp);
    chk("RxReady",  W'(bus.RxReady),  W'(exp_ready));
    chk("AckValid", W'(bus.AckValid), W'(m_ack_v));
    chk("AckTag",   W'(bus.AckTag),   W'(m_ack_tag));
    chk("OutValid", W'(bus.OutValid), W'(exp_ov));
    chk("DupCount", W'(bus.DupCount), W'(m_dup));
    if (exp_ov) chk("OutData", bus.OutData, m_win[m_exp]);
    @(posedge clk);
    if (rv && exp_ready) begin
      d = modt(tag - m_exp);
      if (d < ND && !m_win.exists(tag)) m_win[tag] = pkt;
      else if (m_dup < 65535) m_dup++;
      m_ack_v   = 1;
      m_ack_tag = tag;
    end else if (ar) begin
      m_ack_v = 0;
    end
    if (exp_ov && orr) begin
      m_win.delete(m_exp);
      m_exp = modt(m_exp + 1);
    end
  endtask

  task automatic drain();
    repeat (10) cycle(0, 0, 1, 1);
  endtask

  initial begin
    int e;
    clear_model();
    resetn       = 1'b0;
    bus.RxValid  = 1'b0;
    bus.RxData   = '0;
    bus.AckReady = 1'b0;
    bus.OutReady = 1'b0;
    #12;
    // Reset values
    chk("rst_RxReady",  W'(bus.RxReady),  W'(1));
    chk("rst_OutValid", W'(bus.OutValid), W'(0));
    chk("rst_AckValid", W'(bus.AckValid), W'(0));
    chk("rst_AckTag",   W'(bus.AckTag),   W'(0));
    chk("rst_DupCount", W'(bus.DupCount), W'(0));
    @(negedge clk);
    resetn = 1'b1;

    // In-order stream 0..7
    for (int t = 0; t < 8; t++) cycle(1, t, 1, 1);
    drain();
    chk("inorder_exp", W'(m_exp), W'(8));
    chk("inorder_dup", W'(bus.DupCount), W'(0));

    // Out-of-order fill: head+2, head+1, head+3, then head
    e = m_exp;
    cycle(1, e+2, 1, 1);
    cycle(1, e+1, 1, 1);
    cycle(1, e+3, 1, 1);
    cycle(1, e,   1, 1);
    drain();

    // Duplicate and stale
    e = m_exp;
    saved_dup = m_dup;
    cycle(1, e, 1, 1);
    cycle(0, 0, 1, 1);
    cycle(1, e, 1, 1);       // already delivered -> stale
    cycle(1, e+2, 1, 1);
    cycle(1, e+2, 1, 1);     // duplicate
    cycle(1, e+1, 1, 1);
    drain();
    chk("dupstale_count", W'(bus.DupCount), W'(saved_dup + 2));

    // Wrap-around: 20 consecutive tags
    e = m_exp;
    for (int t = 0; t < 20; t++) cycle(1, e+t, 1, 1);
    drain();
    chk("wrap_exp", W'(m_exp), W'(modt(e + 20)));

    // Tag half a space ahead is stale
    saved_dup = m_dup;
    cycle(1, m_exp + 8, 1, 1);
    cycle(0, 0, 1, 1);
    chk("stale8_dup", W'(bus.DupCount), W'(saved_dup + 1));

    // Ack back-pressure
    e = m_exp;
    cycle(1, e, 1, 1);
    repeat (3) cycle(1, e+1, 0, 1);
    cycle(1, e+1, 1, 1);
    drain();

    // Out back-pressure: head data must stay stable
    e = m_exp;
    cycle(1, e, 1, 0);
    cycle(1, e+1, 1, 0);
    held_data = bus.OutData;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 1, 0);
      chk("hold_OutData", bus.OutData, held_data);
    end
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, m_exp + $urandom_range(0, 15),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    drain();

    // Async reset mid-stream with buffered packets and a pending ack
    e = m_exp;
    if (m_dup == 0) cycle(1, e + 8, 1, 1);
    cycle(1, e,   1, 0);
    cycle(1, e+1, 1, 0);
    cycle(1, e+2, 1, 0);
    @(negedge clk);
    bus.RxValid  = 1'b0;
    bus.AckReady = 1'b0;
    bus.OutReady = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_OutValid", W'(bus.OutValid), W'(0));
    chk("arst_AckValid", W'(bus.AckValid), W'(0));
    chk("arst_DupCount", W'(bus.DupCount), W'(0));
    chk("arst_RxReady",  W'(bus.RxReady),  W'(1));
    clear_model();
    @(negedge clk);
    resetn = 1'b1;
    cycle(1, 0, 1, 0);
    cycle(0, 0, 1, 0);
    chk("arst_new_OutValid", W'(bus.OutValid), W'(1));
    chk("arst_new_dup",      W'(bus.DupCount), W'(0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
